// File: rtl/nonce_sweep_sched.sv
// Nonce sweep scheduler: dispatches a nonce range across NUM_CORES hash cores,
// checks returned hashes against the nBits-decoded target and reports the first winner.
module nonce_sweep_sched #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned NONCE_W   = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           abort,
  input  logic [NONCE_W-1:0]             nonce_start,
  input  logic [NONCE_W-1:0]             nonce_end,
  input  logic [31:0]                    nbits,
  output logic [NUM_CORES-1:0]           core_start,
  output logic [NUM_CORES*NONCE_W-1:0]   core_nonce,
  input  logic [NUM_CORES-1:0]           core_done,
  input  logic [NUM_CORES*256-1:0]       core_hash,
  output logic                           busy,
  output logic                           found,
  output logic [NONCE_W-1:0]             found_nonce,
  output logic [255:0]                   found_hash,
  output logic                           exhausted,
  output logic [NONCE_W:0]               hash_count,
  output logic [255:0]                   target
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN} state_e;

  state_e                         state_q, state_d;
  logic [NONCE_W-1:0]             lo_q, lo_d, hi_q, hi_d, next_q, next_d;
  logic [31:0]                    nbits_q, nbits_d;
  logic                           issued_all_q, issued_all_d;
  logic [NUM_CORES-1:0]           core_busy_q, core_busy_d;
  logic [NUM_CORES-1:0]           core_start_q, core_start_d;
  logic [NUM_CORES*NONCE_W-1:0]   core_nonce_q, core_nonce_d;
  logic                           busy_q, busy_d, found_q, found_d, exhausted_q, exhausted_d;
  logic [NONCE_W-1:0]             found_nonce_q, found_nonce_d;
  logic [255:0]                   found_hash_q, found_hash_d, target_q, target_d;
  logic [NONCE_W:0]               hash_count_q, hash_count_d;

  logic [7:0]                     exp_v, ediff_v;
  logic [7:0]                     sh_v;
  logic [255:0]                   mant_v, dec_target;

  logic [NUM_CORES-1:0]           done_v, busy_after;
  logic [NONCE_W:0]               n_done;
  logic                           win, launch_ok, picked;
  logic [NONCE_W-1:0]             win_nonce, launch_nonce;
  logic [255:0]                   win_hash;

  // Compact nBits decode: sign bit or zero mantissa yields zero, oversized exponent saturates.
  always_comb begin
    exp_v      = nbits_q[31:24];
    mant_v     = {233'b0, nbits_q[22:0]};
    ediff_v    = (exp_v <= 8'd3) ? (8'd3 - exp_v) : (exp_v - 8'd3);
    sh_v       = {ediff_v[4:0], 3'b000};
    dec_target = '0;
    if (nbits_q[23] || (nbits_q[22:0] == 23'd0)) dec_target = '0;
    else if (exp_v <= 8'd3)                      dec_target = mant_v >> sh_v;
    else if (exp_v <= 8'd32)                     dec_target = mant_v << sh_v;
    else                                         dec_target = '1;
  end

  always_comb begin
    state_d       = state_q;
    lo_d          = lo_q;
    hi_d          = hi_q;
    next_d        = next_q;
    nbits_d       = nbits_q;
    issued_all_d  = issued_all_q;
    core_start_d  = '0;
    core_nonce_d  = core_nonce_q;
    found_d       = 1'b0;
    exhausted_d   = 1'b0;
    found_nonce_d = found_nonce_q;
    found_hash_d  = found_hash_q;
    target_d      = target_q;
    hash_count_d  = hash_count_q;
    launch_ok     = 1'b0;
    launch_nonce  = next_q;
    picked        = 1'b0;

    done_v     = core_done & core_busy_q;
    busy_after = core_busy_q & ~done_v;
    n_done     = '0;
    win        = 1'b0;
    win_nonce  = '0;
    win_hash   = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      n_done = n_done + {{NONCE_W{1'b0}}, done_v[k]};
      if (done_v[k] && !win && (core_hash[k*256 +: 256] < target_q)) begin
        win       = 1'b1;
        win_nonce = core_nonce_q[k*NONCE_W +: NONCE_W];
        win_hash  = core_hash[k*256 +: 256];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          lo_d          = nonce_start;
          hi_d          = nonce_end;
          nbits_d       = nbits;
          hash_count_d  = '0;
          found_nonce_d = '0;
          found_hash_d  = '0;
          state_d       = S_LOAD;
        end
      end
      S_LOAD: begin
        target_d     = dec_target;
        next_d       = lo_q;
        issued_all_d = 1'b0;
        if (abort) begin
          state_d = S_DRAIN;
        end else if (hi_q < lo_q) begin
          exhausted_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          // First launch is decided here so its registered pulse lands on the first RUN cycle.
          launch_ok    = 1'b1;
          launch_nonce = lo_q;
          state_d      = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_DRAIN;
        end else if (win) begin
          found_d       = 1'b1;
          found_nonce_d = win_nonce;
          found_hash_d  = win_hash;
          state_d       = S_DRAIN;
        end else if (issued_all_q) begin
          if (busy_after == '0) begin
            exhausted_d = 1'b1;
            state_d     = S_IDLE;
          end
        end else begin
          launch_ok = 1'b1;
        end
      end
      S_DRAIN: begin
        if (busy_after == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE) hash_count_d = hash_count_q + n_done;

    core_busy_d = busy_after;
    if (launch_ok) begin
      for (int unsigned k = 0; k < NUM_CORES; k++) begin
        if (!picked && !busy_after[k]) begin
          picked                             = 1'b1;
          core_start_d[k]                    = 1'b1;
          core_busy_d[k]                     = 1'b1;
          core_nonce_d[k*NONCE_W +: NONCE_W] = launch_nonce;
        end
      end
      if (picked) begin
        if (launch_nonce == hi_q) issued_all_d = 1'b1;
        else                      next_d       = launch_nonce + 1'b1;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      lo_q          <= '0;
      hi_q          <= '0;
      next_q        <= '0;
      nbits_q       <= '0;
      issued_all_q  <= 1'b0;
      core_busy_q   <= '0;
      core_start_q  <= '0;
      core_nonce_q  <= '0;
      busy_q        <= 1'b0;
      found_q       <= 1'b0;
      exhausted_q   <= 1'b0;
      found_nonce_q <= '0;
      found_hash_q  <= '0;
      target_q      <= '0;
      hash_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      lo_q          <= lo_d;
      hi_q          <= hi_d;
      next_q        <= next_d;
      nbits_q       <= nbits_d;
      issued_all_q  <= issued_all_d;
      core_busy_q   <= core_busy_d;
      core_start_q  <= core_start_d;
      core_nonce_q  <= core_nonce_d;
      busy_q        <= busy_d;
      found_q       <= found_d;
      exhausted_q   <= exhausted_d;
      found_nonce_q <= found_nonce_d;
      found_hash_q  <= found_hash_d;
      target_q      <= target_d;
      hash_count_q  <= hash_count_d;
    end
  end

  assign core_start  = core_start_q;
  assign core_nonce  = core_nonce_q;
  assign busy        = busy_q;
  assign found       = found_q;
  assign found_nonce = found_nonce_q;
  assign found_hash  = found_hash_q;
  assign exhausted   = exhausted_q;
  assign hash_count  = hash_count_q;
  assign target      = target_q;

endmodule

// File: tb/tb_nonce_sweep_sched.sv
// Directed bench for nonce_sweep_sched with behavioural fixed-latency hash cores.
module tb_nonce_sweep_sched;
  localparam int unsigned NC = 4;
  localparam int unsigned NW = 32;

  logic              clk, rst_n, start, abort;
  logic [NW-1:0]     nonce_start, nonce_end;
  logic [31:0]       nbits;
  logic [NC-1:0]     core_start, core_done;
  logic [NC*NW-1:0]  core_nonce;
  logic [NC*256-1:0] core_hash;
  logic              busy, found, exhausted;
  logic [NW-1:0]     found_nonce;
  logic [255:0]      found_hash, target;
  logic [NW:0]       hash_count;

  nonce_sweep_sched #(.NUM_CORES(NC), .NONCE_W(NW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .nbits(nbits),
    .core_start(core_start), .core_nonce(core_nonce),
    .core_done(core_done), .core_hash(core_hash),
    .busy(busy), .found(found), .found_nonce(found_nonce), .found_hash(found_hash),
    .exhausted(exhausted), .hash_count(hash_count), .target(target)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned   lat [NC];
  logic          ov_en;
  logic [255:0]  ov_hash [NC];
  int unsigned   cnt [NC];
  logic [NW-1:0] cn [NC];

  // Hash core models: latency lat[k], hash = nonce ^ 0xFF unless overridden.
  initial begin
    core_done = '0;
    core_hash = '0;
    forever begin
      @(negedge clk);
      for (int unsigned k = 0; k < NC; k++) begin
        core_done[k] = 1'b0;
        if (!rst_n) begin
          cnt[k] = 0;
        end else if (core_start[k]) begin
          cnt[k] = lat[k];
          cn[k]  = core_nonce[k*NW +: NW];
        end else if (cnt[k] != 0) begin
          cnt[k] = cnt[k] - 1;
          if (cnt[k] == 0) begin
            core_done[k] = 1'b1;
            core_hash[k*256 +: 256] = ov_en ? ov_hash[k] : {224'b0, cn[k] ^ 32'hFF};
          end
        end
      end
    end
  end

  int unsigned   tot_starts, tot_found, tot_exh, starts_at_found;
  logic [NW-1:0] launched [$];

  initial begin
    tot_starts = 0; tot_found = 0; tot_exh = 0; starts_at_found = 0;
    forever begin
      @(negedge clk);
      if (found) begin
        tot_found++;
        starts_at_found = tot_starts;
      end
      for (int unsigned k = 0; k < NC; k++)
        if (core_start[k]) begin
          launched.push_back(core_nonce[k*NW +: NW]);
          tot_starts++;
        end
      if (exhausted) tot_exh++;
    end
  end

  int unsigned passes = 0, checks = 0;
  int unsigned s0, f0, e0, q0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic snap();
    s0 = tot_starts; f0 = tot_found; e0 = tot_exh; q0 = launched.size();
  endtask

  task automatic start_sweep(input logic [NW-1:0] lo, input logic [NW-1:0] hi, input logic [31:0] nb);
    snap();
    nonce_start = lo; nonce_end = hi; nbits = nb; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned max_cycles);
    for (int unsigned i = 0; i < max_cycles; i++) begin
      tick();
      if (!busy) break;
    end
    chk("idle_timeout", {255'b0, busy}, 256'd0);
    tick();
  endtask

  task automatic run_empty(input logic [31:0] nb, input logic [255:0] exp_t);
    start_sweep(32'd5, 32'd4, nb);
    tick();
    chk("empty_exhausted", {255'b0, exhausted}, 256'd1);
    chk("decode_target", target, exp_t);
    chk("empty_busy", {255'b0, busy}, 256'd0);
    tick();
    chk("empty_no_launch", 256'(tot_starts - s0), 256'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    nonce_start = '0; nonce_end = '0; nbits = '0; ov_en = 1'b0;
    for (int unsigned k = 0; k < NC; k++) begin
      lat[k] = 5; ov_hash[k] = '0;
    end
    repeat (3) tick();
    chk("rst_busy", {255'b0, busy}, 256'd0);
    chk("rst_target", target, 256'd0);
    chk("rst_hash_count", 256'(hash_count), 256'd0);
    chk("rst_core_nonce", 256'(core_nonce), 256'd0);
    chk("rst_core_start", 256'(core_start), 256'd0);
    chk("rst_found_hash", found_hash, 256'd0);
    rst_n = 1'b1;
    tick();

    // Target decode, exercised through empty ranges (also checks empty-range exhaustion).
    run_empty(32'h1d00ffff, 256'hffff << 208);
    run_empty(32'h22000001, {256{1'b1}});
    run_empty(32'h03800001, 256'd0);
    run_empty(32'h03000010, 256'h10);
    run_empty(32'h02001234, 256'h12);

    // Find: winner 0xF0 with hash 0x0F.
    start_sweep(32'h0, 32'h1FF, 32'h03000010);
    chk("find_no_start_c1", 256'(core_start), 256'd0);
    tick();
    chk("find_first_start_c2", 256'(core_start), 256'd1);
    chk("find_first_nonce", 256'(core_nonce[NW-1:0]), 256'd0);
    wait_idle(3000);
    chk("find_found_once", 256'(tot_found - f0), 256'd1);
    chk("find_nonce", 256'(found_nonce), 256'hF0);
    chk("find_hash", found_hash, 256'h0F);
    chk("find_no_start_after", 256'(tot_starts), 256'(starts_at_found));
    chk("find_no_exhaust", 256'(tot_exh - e0), 256'd0);

    // Exhaust: 16 nonces, none winning.
    start_sweep(32'h0, 32'hF, 32'h03000010);
    wait_idle(500);
    chk("exh_starts", 256'(tot_starts - s0), 256'd16);
    for (int unsigned i = 0; i < 16; i++)
      if (q0 + i < launched.size()) chk("exh_nonce_order", 256'(launched[q0 + i]), 256'(i));
    chk("exh_once", 256'(tot_exh - e0), 256'd1);
    chk("exh_hash_count", 256'(hash_count), 256'd16);
    chk("exh_no_found", 256'(tot_found - f0), 256'd0);

    // Range ending at the top of the nonce space must not wrap.
    start_sweep(32'hFFFFFFFE, 32'hFFFFFFFF, 32'h03000010);
    wait_idle(200);
    repeat (5) tick();
    chk("wrap_starts", 256'(tot_starts - s0), 256'd2);
    if (q0 + 1 < launched.size()) begin
      chk("wrap_nonce0", 256'(launched[q0]), 256'hFFFFFFFE);
      chk("wrap_nonce1", 256'(launched[q0 + 1]), 256'hFFFFFFFF);
    end
    chk("wrap_exhausted", 256'(tot_exh - e0), 256'd1);
    chk("wrap_hash_count", 256'(hash_count), 256'd2);

    // Simultaneous winners: cores 1 and 3 both complete at cycle 9.
    lat[0] = 5; lat[1] = 6; lat[2] = 6; lat[3] = 4;
    ov_hash[0] = '1; ov_hash[1] = 256'h3; ov_hash[2] = '1; ov_hash[3] = 256'h1;
    ov_en = 1'b1;
    start_sweep(32'h0, 32'hFF, 32'h03000010);
    wait_idle(200);
    chk("sim_found_once", 256'(tot_found - f0), 256'd1);
    chk("sim_found_hash", found_hash, 256'h3);
    chk("sim_found_nonce", 256'(found_nonce), 256'd1);
    ov_en = 1'b0;
    for (int unsigned k = 0; k < NC; k++) lat[k] = 5;

    // Abort with all four cores busy.
    start_sweep(32'h0, 32'h1FF, 32'h03000010);
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (3) tick();
    chk("abort_busy_c10", {255'b0, busy}, 256'd1);
    tick();
    chk("abort_idle_c11", {255'b0, busy}, 256'd0);
    chk("abort_hash_count", 256'(hash_count), 256'd4);
    tick();
    chk("abort_starts", 256'(tot_starts - s0), 256'd4);
    chk("abort_no_found", 256'(tot_found - f0), 256'd0);
    chk("abort_no_exh", 256'(tot_exh - e0), 256'd0);

    // Reset mid-RUN.
    start_sweep(32'h0, 32'h1FF, 32'h03000010);
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_busy", {255'b0, busy}, 256'd0);
    chk("mid_rst_target", target, 256'd0);
    chk("mid_rst_hash_count", 256'(hash_count), 256'd0);
    chk("mid_rst_core_nonce", 256'(core_nonce), 256'd0);
    chk("mid_rst_core_start", 256'(core_start), 256'd0);
    chk("mid_rst_pulses", {254'b0, found, exhausted}, 256'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_idle", {255'b0, busy}, 256'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/nonce_sweep_sched.md
# nonce_sweep_sched

Parametrised successor to the single-core miner controller. The block takes a block-header nonce range and a compact (nBits) difficulty target, and dispatches nonces across `NUM_CORES` external double-SHA256 cores. It checks each returned hash against the decoded 256-bit target and reports the first winning nonce, or range exhaustion. It sits between the Wishbone/LA register front-end (which supplies range, nBits and start) and the replicated `miner` instances.

## Interface
Parameters:
- `NUM_CORES`, default 4: number of hash cores, 1..16.
- `NONCE_W`, default 32: nonce width.

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle pulse; sampled only in IDLE.
- `abort`  in  1  one-cycle pulse; ends the sweep without reporting.
- `nonce_start`  in  NONCE_W  first nonce, inclusive; sampled with `start`.
- `nonce_end`  in  NONCE_W  last nonce, inclusive; sampled with `start`.
- `nbits`  in  32  compact target; sampled with `start`.
- `core_start`  out  NUM_CORES  per-core one-cycle launch pulse.
- `core_nonce`  out  NUM_CORES*NONCE_W  per-core nonce; slice k is held stable from launch until that core's done.
- `core_done`  in  NUM_CORES  per-core one-cycle completion pulse.
- `core_hash`  in  NUM_CORES*256  per-core hash, numeric big-endian; valid only with `core_done`.
- `busy`  out  1  high in every state except IDLE.
- `found`  out  1  one-cycle pulse: a winner was found.
- `found_nonce`  out  NONCE_W  winning nonce; held until next `start`.
- `found_hash`  out  256  winning hash; held until next `start`.
- `exhausted`  out  1  one-cycle pulse: range complete with no winner.
- `hash_count`  out  NONCE_W+1  count of accepted `core_done` pulses since the last `start`.
- `target`  out  256  registered decoded target.

## Operation
States: IDLE, LOAD, RUN, DRAIN.
- IDLE + `start`: latch range and nbits, clear `hash_count`, `found_nonce`, `found_hash`; go to LOAD.
- LOAD, 1 cycle: register the decoded `target`.
  - If `nonce_end < nonce_start`, assert `exhausted` and go to IDLE.
  - Otherwise set `next_nonce = nonce_start`, clear `issued_all`, go to RUN.
- Target decode. Let E = nbits[31:24] and M = nbits[22:0]:
  - If nbits[23]=1 or M=0: target = 0.
  - Else if E≤3: target = M >> 8*(3−E).
  - Else if E≤32: target = M << 8*(E−3).
  - Else (E>32): target = all-ones.
- RUN dispatch: at most one launch per cycle.
  - Launch goes to the lowest-index idle core, and only while `!issued_all`.
  - On launch: `core_nonce[k] = next_nonce`; the core is marked busy.
  - If `next_nonce == nonce_end`, set `issued_all`; otherwise increment `next_nonce`. The counter never wraps past `nonce_end`, including at 2^NONCE_W−1.
- Result check: in every non-IDLE state, each `core_done[k]` clears busy[k] and increments `hash_count`. Several cores may complete in the same cycle.
- Win rule, RUN only: hash < target, strict unsigned 256-bit compare. Among cores completing in the same cycle, the lowest-index winner takes priority.
  - On a win: register `found_nonce`/`found_hash`, pulse `found`, go to DRAIN.
- Exhaustion: in RUN, when `issued_all`, no core busy, and no win this cycle, pulse `exhausted` and go to IDLE. `found` has priority over `exhausted` in the same cycle.
- `abort` in LOAD or RUN goes to DRAIN; no `found` or `exhausted` is reported. `abort` in IDLE or DRAIN is ignored.
- DRAIN: no launches. Results are counted but never reported. Go to IDLE once no core is busy; this can happen on the entry cycle.
- `start` outside IDLE is ignored.
- `core_done` on a non-busy core is ignored and not counted.

## Timing
- Reset (`rst_n` low at a clk edge): state IDLE; all outputs 0, including `target`, `found_nonce`, `found_hash`, `hash_count`, `core_nonce`. All busy flags cleared. Reset mid-sweep discards everything; the cores share the reset.
- `start` at cycle 0 → LOAD at cycle 1 → first `core_start` at cycle 2.
- A core whose `core_done` arrives at cycle t can be relaunched at cycle t+1 at the earliest.
- Win on `core_done` at cycle t → `found` at t+1 with `found_nonce` valid; no `core_start` at t+1 or later. A launch at cycle t itself is permitted and is drained.
- All outputs are registered; `core_start` is a registered pulse aligned with `core_nonce`.

## Test plan
Test cores have fixed latency 5 and return hash = {224'b0, nonce ^ 32'hFF}. With nbits=0x03000010, target=0x10, so hashes win only for nonces 0xF0..0xFF.
- Decode: nbits=0x1d00ffff → `target` = 0xffff<<208. nbits=0x22000001 → all-ones. nbits=0x03800001 → 0.
- Find: range 0x000..0x1FF, NUM_CORES=4 → `found` once, `found_nonce`=0xF0, `found_hash`=0x0F, no `core_start` after `found`, `busy` low after the drain.
- Exhaust: range 0x00..0x0F → 16 `core_start` pulses with nonces 0..15, `exhausted` once, `hash_count`=16, no `found`.
- Wrap and empty range: range 0xFFFFFFFE..0xFFFFFFFF → exactly 2 launches, then `exhausted`. Range 5..4 → `exhausted` at cycle 2, zero launches.
- Simultaneous: cores 1 and 3 return winning hashes 0x3 and 0x1 in the same cycle → `found_hash`=0x3, the core 1 result.
- Abort and reset: `abort` with 4 cores busy → no `found` or `exhausted`, `busy` drops the cycle after the last `core_done`. `rst_n` low mid-RUN → next cycle all outputs are 0 and the state is IDLE.
